rx_frame_arbiter: RTL
=====================

RX_FRAME_ARBITER -- requirements
Module: rx_frame_arbiter

Interface
REQ-001 Parameter FRAME_LEN, default 8, SHALL set the bytes per command frame (legal range 1..2^CW-1).
REQ-002 Parameter CW, default 5, SHALL set the receive-FIFO count width (equal to the UART FIFO counter width).
REQ-003 Parameter TIMEOUT, default 4096, SHALL set the mid-frame starvation limit in clk cycles (legal range >= 2).
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rf_count_a  in  CW  fill level of UART A receive FIFO.
REQ-007 rdr_a  in  8  head byte of UART A receive FIFO; updates the cycle after a pop.
REQ-008 rf_pop_a  out  1  one-cycle pop strobe to UART A receive FIFO.
REQ-009 rf_count_b, rdr_b, rf_pop_b  in/in/out  CW/8/1  same as REQ-006..008, for UART B.
REQ-010 cmd_data  out  8  byte presented to the command parser.
REQ-011 cmd_valid  out  1  cmd_data is valid.
REQ-012 cmd_ready  in  1  parser accepts the byte.
REQ-013 cmd_sof / cmd_eof  out  1/1  first / last byte of the frame; meaningful only while cmd_valid is high.
REQ-014 grant  out  1  0 = UART A, 1 = UART B; the source of the current or most recent frame.
REQ-015 busy  out  1  high when the state is not IDLE.
REQ-016 timeout_err  out  1  one-cycle pulse when a frame is abandoned.

Function
REQ-017 States SHALL be IDLE, FETCH, PRESENT and WAIT.
REQ-018 A source SHALL be eligible in IDLE when its rf_count >= FRAME_LEN.
REQ-019 IDLE arbitration:
- one source eligible -> grant that source;
- both eligible -> grant the source opposite the previous grant (round-robin);
- grant and the last-grant register update on the transition to FETCH.
REQ-020 FETCH SHALL last exactly one cycle:
- assert the granted rf_pop;
- register the granted rdr into cmd_data;
- go to PRESENT.
REQ-021 cmd_valid SHALL be high exactly while in PRESENT.
- Eligibility sampled at edge N -> rf_pop high in cycle N+1 -> cmd_valid high from cycle N+2.
REQ-022 cmd_data, cmd_sof and cmd_eof SHALL stay stable while cmd_valid is high and cmd_ready is low; a consumer stall never times out.
REQ-023 A handshake is cmd_valid & cmd_ready at an edge. On a handshake:
- last byte (byte index FRAME_LEN-1) -> IDLE;
- else granted rf_count > 0 -> FETCH;
- else -> WAIT.
REQ-024 WAIT:
- granted rf_count > 0 -> FETCH;
- after TIMEOUT consecutive cycles in WAIT -> IDLE with timeout_err pulsed for one cycle;
- the remaining bytes of an abandoned frame stay in the FIFO and are not flushed.
REQ-025 cmd_sof SHALL be high on byte index 0; cmd_eof SHALL be high on byte index FRAME_LEN-1; with FRAME_LEN = 1 both are high on the same byte.
REQ-026 The byte index SHALL be ceil(log2(FRAME_LEN+1)) bits wide, clear at frame start, and increment on each handshake.
REQ-027 The timeout counter SHALL clear on every entry to WAIT and SHALL saturate, never wrap.
REQ-028 The non-granted rf_pop SHALL never assert; rf_pop_a and rf_pop_b are never high together.
REQ-029 Eligibility changes during a frame SHALL not change grant.
REQ-030 Per frame, exactly FRAME_LEN pops on completion; on abandon, the number of pops equals the number of bytes presented.

Reset
REQ-031 Asynchronous reset (rst_n low) SHALL set:
- state IDLE;
- cmd_valid, cmd_sof, cmd_eof, rf_pop_a, rf_pop_b, timeout_err, busy = 0;
- cmd_data = 8'h00, grant = 0;
- last-grant register = 1, so UART A wins the first tie;
- byte index and timeout counter = 0.
REQ-032 Reset mid-frame SHALL abandon the frame immediately with no timeout_err; the first cycle after release is IDLE.

Structure
REQ-033 The shared package SHALL hold the state enum, the default FRAME_LEN, CW and TIMEOUT constants, and the grant encoding (GRANT_A = 0, GRANT_B = 1).
REQ-034 One sub-module, frame_wdog_timer, SHALL implement the WAIT timeout counter (inputs: clear, enable; output: expired); everything else is flat.

Verification
REQ-035 Scenario: rf_count_a 0 -> 8, rf_count_b = 0, cmd_ready = 1 -> rf_pop_a high 1 cycle after eligibility; cmd_valid 2 cycles after; 8 bytes in FIFO order; sof on byte 0, eof on byte 7; grant = 0; rf_pop_b never asserts.
REQ-036 Scenario: both FIFOs reach 8 on the same cycle after reset -> frame A, then frame B; repeat -> A then B again.
REQ-037 Scenario: cmd_ready held low for 10000 cycles on byte 3 -> cmd_data stable, no timeout_err, no extra pops; the frame completes once ready returns.
REQ-038 Scenario: FRAME_LEN = 8, UART A supplies 8 bytes but the FIFO is emptied externally after byte 5 pop, TIMEOUT = 16 -> WAIT for 16 cycles, one timeout_err pulse, return to IDLE, no eof.
REQ-039 Scenario: rst_n asserted during PRESENT of byte 4 -> all outputs at reset values asynchronously; no timeout_err; the next frame starts with sof and grant = A on a tie.
REQ-040 Scenario: FRAME_LEN = 1, alternating single bytes on A and B -> sof and eof together on every byte; grant toggles each frame.

Source files
------------

// File: rtl/rx_frame_arbiter_pkg.sv
// Shared definitions for the receive-frame arbiter: FSM state encoding,
// default frame geometry / timeout constants, grant encoding and the
// round-robin pick helper.
package rx_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_WAIT
  } arb_state_e;

  localparam int unsigned FRAME_LEN_DEFAULT = 8;
  localparam int unsigned CW_DEFAULT        = 5;
  localparam int unsigned TIMEOUT_DEFAULT   = 4096;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // A lone eligible source wins outright; on a tie the source opposite the
  // previous grant wins.
  function automatic logic rr_pick(input logic elig_a, input logic elig_b,
                                   input logic last_grant);
    logic pick;
    if (elig_a && elig_b) pick = ~last_grant;
    else if (elig_b)      pick = GRANT_B;
    else                  pick = GRANT_A;
    return pick;
  endfunction

endpackage

// File: rtl/rx_frame_arbiter_wdog.sv
// frame_wdog_timer: mid-frame starvation counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the counter (asserted on entry to the waiting state)
//   enable     : count while high; saturates at TIMEOUT-1, never wraps
//   expired    : high on the TIMEOUT-th consecutive enabled cycle
module frame_wdog_timer
  import rx_frame_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)                          count_d = '0;
    else if (enable && count_q != LIMIT) count_d = count_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/rx_frame_arbiter.sv
// rx_frame_arbiter: picks whole command frames from one of two UART receive
// FIFOs and streams them byte by byte to the command parser.
//   rf_count_a/b, rdr_a/b : FIFO fill level and head byte per UART
//   rf_pop_a/b            : one-cycle pop strobes (only the granted side)
//   cmd_data/valid/ready  : byte stream to the parser
//   cmd_sof/cmd_eof       : first/last byte of frame, qualified by cmd_valid
//   grant                 : 0 = UART A, 1 = UART B (current/most recent frame)
//   busy                  : not idle
//   timeout_err           : one-cycle pulse when a starved frame is abandoned
module rx_frame_arbiter
  import rx_frame_arbiter_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] rf_count_a,
  input  logic [7:0]    rdr_a,
  output logic          rf_pop_a,
  input  logic [CW-1:0] rf_count_b,
  input  logic [7:0]    rdr_b,
  output logic          rf_pop_b,
  output logic [7:0]    cmd_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_sof,
  output logic          cmd_eof,
  output logic          grant,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned   IW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL_CNT   = CW'(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          terr_q, terr_d;

  logic          elig_a, elig_b;
  logic          g_has_data;
  logic [7:0]    g_rdr;
  logic          wd_clear, wd_enable, wd_expired;

  assign elig_a     = rf_count_a >= FL_CNT;
  assign elig_b     = rf_count_b >= FL_CNT;
  assign g_has_data = (grant_q == GRANT_B) ? (rf_count_b != '0) : (rf_count_a != '0);
  assign g_rdr      = (grant_q == GRANT_B) ? rdr_b : rdr_a;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    data_d   = data_q;
    idx_d    = idx_q;
    terr_d   = 1'b0;
    wd_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig_a || elig_b) begin
          grant_d = rr_pick(elig_a, elig_b, last_q);
          last_d  = grant_d;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        data_d  = g_rdr;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (cmd_ready) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else if (g_has_data) begin
            state_d = ST_FETCH;
          end else begin
            state_d  = ST_WAIT;
            wd_clear = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Arriving data takes priority over an expiry in the same cycle.
        if (g_has_data) begin
          state_d = ST_FETCH;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_A;
      last_q  <= GRANT_B;
      data_q  <= '0;
      idx_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      terr_q  <= terr_d;
    end
  end

  assign wd_enable = (state_q == ST_WAIT);

  frame_wdog_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  assign cmd_valid   = (state_q == ST_PRESENT);
  assign cmd_data    = data_q;
  assign cmd_sof     = cmd_valid && (idx_q == '0);
  assign cmd_eof     = cmd_valid && (idx_q == LAST_IDX);
  assign rf_pop_a    = (state_q == ST_FETCH) && (grant_q == GRANT_A);
  assign rf_pop_b    = (state_q == ST_FETCH) && (grant_q == GRANT_B);
  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;

endmodule
